// File: rtl/seq_code_pkg.sv
// rtl/seq_code_pkg.sv - shared constants, state type and helpers for the sequence code checker
//
// Purpose: the 14-entry scrambled code sequence (S0..S13), the illegal
// code set, the sequence length, the checker state enum and the
// successor function on linear indices.
package seq_code_pkg;

  localparam int SEQ_LEN = 14;

  localparam logic [3:0] S0  = 4'd8;
  localparam logic [3:0] S1  = 4'd7;
  localparam logic [3:0] S2  = 4'd11;
  localparam logic [3:0] S3  = 4'd4;
  localparam logic [3:0] S4  = 4'd9;
  localparam logic [3:0] S5  = 4'd2;
  localparam logic [3:0] S6  = 4'd5;
  localparam logic [3:0] S7  = 4'd12;
  localparam logic [3:0] S8  = 4'd6;
  localparam logic [3:0] S9  = 4'd3;
  localparam logic [3:0] S10 = 4'd15;
  localparam logic [3:0] S11 = 4'd1;
  localparam logic [3:0] S12 = 4'd14;
  localparam logic [3:0] S13 = 4'd13;

  // Codes the upstream counter never produces.
  localparam logic [3:0] ILL_CODE_A = 4'd0;
  localparam logic [3:0] ILL_CODE_B = 4'd10;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_e;

  // Next index in the cyclic sequence.
  function automatic logic [3:0] succ(input logic [3:0] i);
    return (i == 4'(SEQ_LEN - 1)) ? 4'd0 : i + 4'd1;
  endfunction

endpackage

// File: rtl/seq_code_if.sv
// rtl/seq_code_if.sv - code input and status output bundle of the sequence code checker
//
// Purpose: groups the sampled code inputs and the registered status outputs.
// master : producer/observer side (drives code_in, code_vld, clr_cnt).
// slave  : checker side (drives index, index_vld, locked, seq_err,
//          illegal, wrap, lap_cnt, err_cnt).
interface seq_code_if #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 8
);
  logic [3:0]       code_in;
  logic             code_vld;
  logic             clr_cnt;
  logic [3:0]       index;
  logic             index_vld;
  logic             locked;
  logic             seq_err;
  logic             illegal;
  logic             wrap;
  logic [LAP_W-1:0] lap_cnt;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output code_in, code_vld, clr_cnt,
    input  index, index_vld, locked, seq_err, illegal, wrap, lap_cnt, err_cnt
  );

  modport slave (
    input  code_in, code_vld, clr_cnt,
    output index, index_vld, locked, seq_err, illegal, wrap, lap_cnt, err_cnt
  );
endinterface

// File: rtl/seq_code_decode.sv
// rtl/seq_code_decode.sv - combinational code to linear index decoder
//
// Purpose: maps a 4-bit code to its position 0..13 in the sequence.
// Ports: code_in (in, 4) code to decode; legal (out, 1) code is in the
// sequence; idx (out, 4) linear index, 0 when illegal.
module seq_code_decode
  import seq_code_pkg::*;
(
  input  logic [3:0] code_in,
  output logic       legal,
  output logic [3:0] idx
);

  always_comb begin
    legal = 1'b1;
    idx   = 4'd0;
    case (code_in)
      S0:         idx = 4'd0;
      S1:         idx = 4'd1;
      S2:         idx = 4'd2;
      S3:         idx = 4'd3;
      S4:         idx = 4'd4;
      S5:         idx = 4'd5;
      S6:         idx = 4'd6;
      S7:         idx = 4'd7;
      S8:         idx = 4'd8;
      S9:         idx = 4'd9;
      S10:        idx = 4'd10;
      S11:        idx = 4'd11;
      S12:        idx = 4'd12;
      S13:        idx = 4'd13;
      ILL_CODE_A: legal = 1'b0;
      ILL_CODE_B: legal = 1'b0;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_code_checker.sv
// rtl/seq_code_checker.sv - sequence checker for the 14-state scrambled code counter
//
// Purpose: samples codes while code_vld is high, decodes them, tracks
// HUNT/SYNC/LOCK alignment and reports index, lock, error pulses and
// lap/error statistics. All outputs are registered (1-cycle latency).
// Ports: clk (in) rising-edge clock; reset (in) async active-high;
// bus (seq_code_if.slave) code_in/code_vld/clr_cnt in, status out.
module seq_code_checker
  import seq_code_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_ERR = 2,
  parameter int LAP_W      = 8,
  parameter int ERR_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  seq_code_if.slave   bus
);

  localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_ERR_C = 4'(UNLOCK_ERR);

  logic       legal;
  logic [3:0] idx;

  seq_code_decode u_decode (
    .code_in (bus.code_in),
    .legal   (legal),
    .idx     (idx)
  );

  state_e           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       index_q, index_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic             index_vld_q, index_vld_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal_q, illegal_d;
  logic             wrap_q, wrap_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic       err_event;

  assign good_inc = good_cnt_q + 4'd1;
  assign bad_inc  = bad_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    index_d     = index_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    index_vld_d = 1'b0;
    seq_err_d   = 1'b0;
    illegal_d   = 1'b0;
    wrap_d      = 1'b0;

    if (bus.code_vld) begin
      if (!legal) begin
        // Illegal code: prev and index keep their last legal values.
        illegal_d = 1'b1;
        case (state_q)
          SYNC: state_d = HUNT;
          LOCK: begin
            bad_cnt_d = bad_inc;
            if (bad_inc == UNLOCK_ERR_C) begin
              state_d    = HUNT;
              good_cnt_d = 4'd0;
            end
          end
          default: ;
        endcase
      end else begin
        index_d     = idx;
        index_vld_d = 1'b1;
        prev_d      = idx;
        if (state_q == HUNT) begin
          good_cnt_d = 4'd0;
          state_d    = SYNC;
        end else if (idx == prev_q) begin
          // Upstream counter held: neither progress nor error.
        end else if (idx == succ(prev_q)) begin
          if (state_q == SYNC) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_CNT_C) begin
              state_d   = LOCK;
              bad_cnt_d = 4'd0;
            end
          end else begin
            bad_cnt_d = 4'd0;
            wrap_d    = (prev_q == 4'(SEQ_LEN - 1));
          end
        end else if (state_q == SYNC) begin
          good_cnt_d = 4'd0;
        end else begin
          // Out-of-sequence in LOCK: flag it and resync prev to the new position.
          seq_err_d = 1'b1;
          bad_cnt_d = bad_inc;
          if (bad_inc == UNLOCK_ERR_C) begin
            state_d    = HUNT;
            good_cnt_d = 4'd0;
          end
        end
      end
    end
  end

  assign err_event = seq_err_d | illegal_d;

  // The clear takes priority over an increment in the same cycle.
  always_comb begin
    lap_cnt_d = lap_cnt_q;
    err_cnt_d = err_cnt_q;
    if (bus.clr_cnt) begin
      lap_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (wrap_d) lap_cnt_d = lap_cnt_q + LAP_W'(1);
      if (err_event && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= 4'd0;
      index_q     <= 4'd0;
      good_cnt_q  <= 4'd0;
      bad_cnt_q   <= 4'd0;
      index_vld_q <= 1'b0;
      seq_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
      wrap_q      <= 1'b0;
      lap_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      index_q     <= index_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      index_vld_q <= index_vld_d;
      seq_err_q   <= seq_err_d;
      illegal_q   <= illegal_d;
      wrap_q      <= wrap_d;
      lap_cnt_q   <= lap_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.index     = index_q;
  assign bus.index_vld = index_vld_q;
  assign bus.locked    = (state_q == LOCK);
  assign bus.seq_err   = seq_err_q;
  assign bus.illegal   = illegal_q;
  assign bus.wrap      = wrap_q;
  assign bus.lap_cnt   = lap_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seq_code_checker.sv
// tb/tb_seq_code_checker.sv - self-checking bench for seq_code_checker
module tb_seq_code_checker;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_ERR = 2;
  localparam int LAP_W      = 8;
  localparam int ERR_W      = 8;

  logic clk = 1'b0;
  logic reset;

  seq_code_if #(.LAP_W(LAP_W), .ERR_W(ERR_W)) sif ();

  seq_code_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_ERR (UNLOCK_ERR),
    .LAP_W      (LAP_W),
    .ERR_W      (ERR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  int seq_tab [14] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13};

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: mode 0=hunting, 1=syncing, 2=locked.
  int m_mode, m_prev, m_good, m_bad;
  int e_index, e_lap, e_err;
  bit e_vld, e_seq, e_ill, e_wrap;

  function automatic int code_pos(input int code);
    for (int k = 0; k < 14; k++) if (seq_tab[k] == code) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_good = 0; m_bad = 0;
    e_index = 0; e_lap = 0; e_err = 0;
    e_vld = 0; e_seq = 0; e_ill = 0; e_wrap = 0;
  endtask

  task automatic model_bad();
    m_bad++;
    if (m_bad == UNLOCK_ERR) begin m_mode = 0; m_good = 0; end
  endtask

  task automatic model_step(input bit vld, input int code, input bit clr);
    int p;
    e_vld = 0; e_seq = 0; e_ill = 0; e_wrap = 0;
    if (vld) begin
      p = code_pos(code);
      if (p < 0) begin
        e_ill = 1;
        if (m_mode == 1) m_mode = 0;
        else if (m_mode == 2) model_bad();
      end else begin
        e_index = p; e_vld = 1;
        if (m_mode == 0) begin
          m_good = 0; m_mode = 1;
        end else if (p == m_prev) begin
        end else if (p == (m_prev + 1) % 14) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
          end else begin
            m_bad = 0;
            e_wrap = (m_prev == 13);
          end
        end else if (m_mode == 1) begin
          m_good = 0;
        end else begin
          e_seq = 1;
          model_bad();
        end
        m_prev = p;
      end
    end
    if (clr) begin
      e_lap = 0; e_err = 0;
    end else begin
      if (e_wrap) e_lap = (e_lap + 1) % (1 << LAP_W);
      if ((e_seq || e_ill) && e_err < (1 << ERR_W) - 1) e_err++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] act, exp;
      act = {4'(sif.index), sif.index_vld, sif.locked, sif.seq_err, sif.illegal,
             sif.wrap, 1'b0, 8'(sif.lap_cnt), 8'(sif.err_cnt)};
      exp = {4'(e_index), e_vld, (m_mode == 2), e_seq, e_ill,
             e_wrap, 1'b0, 8'(e_lap), 8'(e_err)};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t: got idx=%0d vld=%0b lk=%0b se=%0b il=%0b wr=%0b lap=%0d err=%0d expected idx=%0d vld=%0b lk=%0b se=%0b il=%0b wr=%0b lap=%0d err=%0d",
                 $time, act[31:28], act[27], act[26], act[25], act[24], act[23], act[15:8], act[7:0],
                 exp[31:28], exp[27], exp[26], exp[25], exp[24], exp[23], exp[15:8], exp[7:0]);
      end
    end
  end

  task automatic step(input bit vld, input logic [3:0] code, input bit clr);
    sif.code_vld = vld;
    sif.code_in  = code;
    sif.clr_cnt  = clr;
    @(posedge clk);
    model_step(vld, int'(code), clr);
    #1;
  endtask

  task automatic step_code(input int code);
    step(1'b1, 4'(code), 1'b0);
  endtask

  // Drive n in-sequence codes starting at index start.
  task automatic run_seq(input int start, input int n);
    for (int k = 0; k < n; k++) step_code(seq_tab[(start + k) % 14]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_index"},   int'(sif.index), 0);
    check({tag, "_flags"},   int'({sif.index_vld, sif.locked, sif.seq_err, sif.illegal, sif.wrap}), 0);
    check({tag, "_lap_cnt"}, int'(sif.lap_cnt), 0);
    check({tag, "_err_cnt"}, int'(sif.err_cnt), 0);
  endtask

  int rnd_idx;
  int r;
  bit rclr;

  initial begin
    sif.code_vld = 1'b0;
    sif.code_in  = 4'd0;
    sif.clr_cnt  = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Full lap: lock after code 4, wrap on 13 -> 8.
    run_seq(0, 4);
    check("lock_after_4th", int'(sif.locked), 1);
    run_seq(4, 11);
    check("lap1_lap_cnt", int'(sif.lap_cnt), 1);
    check("lap1_err_cnt", int'(sif.err_cnt), 0);
    check("lap1_index",   int'(sif.index), 0);

    // Single out-of-sequence jump while locked.
    run_seq(1, 4);
    step_code(12);
    check("jump_seq_err", int'(sif.seq_err), 1);
    check("jump_index",   int'(sif.index), 7);
    run_seq(8, 2);
    check("jump_err_cnt", int'(sif.err_cnt), 1);
    check("jump_locked",  int'(sif.locked), 1);

    // Two consecutive jumps unlock.
    step_code(12);
    step_code(1);
    check("unlock_locked",  int'(sif.locked), 0);
    check("unlock_err_cnt", int'(sif.err_cnt), 3);

    // Illegal code in HUNT, SYNC and LOCK.
    step_code(10);
    check("ill_hunt_pulse", int'(sif.illegal), 1);
    check("ill_hunt_index", int'(sif.index), 11);
    step_code(8);
    step_code(10);
    check("ill_sync_locked", int'(sif.locked), 0);
    run_seq(0, 4);
    step_code(10);
    check("ill_lock_locked", int'(sif.locked), 1);
    check("ill_lock_index",  int'(sif.index), 3);
    check("ill_lock_err",    int'(sif.err_cnt), 6);

    // Holds and idle cycles while locked at index 3.
    run_seq(4, 13);
    repeat (5) step_code(4);
    repeat (3) step(1'b0, 4'd9, 1'b0);
    check("hold_index",  int'(sif.index), 3);
    check("hold_locked", int'(sif.locked), 1);
    check("hold_err",    int'(sif.err_cnt), 6);

    // Error counter saturation.
    for (int k = 0; k < 260; k++) step_code((k % 2) ? 0 : 10);
    check("sat_err", int'(sif.err_cnt), 255);
    step_code(0);
    check("sat_err_hold", int'(sif.err_cnt), 255);

    // Clear coincident with a wrap.
    run_seq(0, 14);
    step(1'b1, 4'd8, 1'b1);
    check("clr_wrap_pulse", int'(sif.wrap), 1);
    check("clr_wrap_lap",   int'(sif.lap_cnt), 0);
    check("clr_wrap_err",   int'(sif.err_cnt), 0);

    // Randomised traffic.
    rnd_idx = 0;
    for (int n = 0; n < 3000; n++) begin
      r    = int'($urandom_range(0, 99));
      rclr = ($urandom_range(0, 99) < 2);
      if (r < 65) begin
        rnd_idx = (rnd_idx + 1) % 14;
        step(1'b1, 4'(seq_tab[rnd_idx]), rclr);
      end else if (r < 75) begin
        step(1'b1, 4'(seq_tab[rnd_idx]), rclr);
      end else if (r < 83) begin
        step(1'b0, 4'($urandom), rclr);
      end else if (r < 89) begin
        step(1'b1, (r % 2) ? 4'd0 : 4'd10, rclr);
      end else begin
        rnd_idx = int'($urandom_range(0, 13));
        step(1'b1, 4'(seq_tab[rnd_idx]), rclr);
      end
    end

    // Asynchronous reset mid-stream.
    run_seq(0, 16);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("async_reset");
    check("async_reset_locked", int'(sif.locked), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_seq(0, 5);
    check("post_reset_locked", int'(sif.locked), 1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
